mem_arb_rr: RTL and testbench



---
 rtl/mem_arb_rr.sv | 130 +++++++++++++
 tb/tb_mem_arb_rr.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb_rr.sv
// N-channel arbiter in front of a single shared memory port.
// Round-robin or fixed-priority grant, one outstanding transaction, done-based memory handshake.
module mem_arb_rr #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_done,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     busy
);

  localparam int unsigned PtrW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [PtrW-1:0]     ch_q, ch_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                win_found;
  logic [PtrW-1:0]     win_idx;

  // Search starts at ptr (round-robin) or at 0 (fixed priority); first asserted channel wins.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (PRIO_MODE != 0) begin
        idx = k;
      end else begin
        idx = 32'(ptr_q) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
      end
      if (!win_found && req_valid[PtrW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = PtrW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          ch_d    = win_idx;
          we_d    = req_we[win_idx];
          addr_d  = req_addr[win_idx*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[win_idx*DATA_W +: DATA_W];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (mem_done) begin
          rdata_d = mem_rdata;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
        if (PRIO_MODE == 0) begin
          ptr_d = (ch_q == PtrW'(NUM_CH - 1)) ? '0 : ch_q + PtrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      ch_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // req_ready is combinational on req_valid, so it must also be forced low while in reset.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (rst_n && (state_q == StIdle) && win_found) req_ready = NUM_CH'(1) << win_idx;
    if (state_q == StResp) resp_valid = NUM_CH'(1) << ch_q;
  end

  assign mem_req    = (state_q == StIssue);
  assign mem_we     = mem_req & we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign resp_rdata = rdata_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arb_rr.sv
// Directed bench for mem_arb_rr: a 2-channel round-robin instance with a variable-latency
// memory model and a scoreboard of expected responses, plus a 3-channel fixed-priority instance.
module tb_mem_arb_rr;

  logic        clock = 1'b0;
  logic        rst_n;

  logic [1:0]  req_valid, req_we, req_ready, resp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_done, busy;

  logic [2:0]  fp_valid, fp_we, fp_ready, fp_resp_valid;
  logic [95:0] fp_addr, fp_wdata;
  logic [31:0] fp_resp_rdata, fp_mem_addr, fp_mem_wdata;
  logic        fp_mem_req, fp_mem_we, fp_busy;

  logic        model_done, stray_done;
  int          lat;
  int          mem_cnt;
  int          cyc;
  int          n_chk;
  int          n_fail;
  int          last_cyc;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  mem_arb_rr #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .PRIO_MODE(0)) u_dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_done   (mem_done),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  mem_arb_rr #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .PRIO_MODE(1)) u_fp (
    .clock      (clock),
    .rst_n      (rst_n),
    .req_valid  (fp_valid),
    .req_we     (fp_we),
    .req_addr   (fp_addr),
    .req_wdata  (fp_wdata),
    .req_ready  (fp_ready),
    .resp_valid (fp_resp_valid),
    .resp_rdata (fp_resp_rdata),
    .mem_req    (fp_mem_req),
    .mem_we     (fp_mem_we),
    .mem_addr   (fp_mem_addr),
    .mem_wdata  (fp_mem_wdata),
    .mem_done   (fp_mem_req),
    .mem_rdata  (fp_mem_addr),
    .busy       (fp_busy)
  );

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  assign mem_done  = model_done | stray_done;
  assign mem_rdata = rd_fn(mem_addr);

  initial forever #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_chk++;
    n_fail++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (req_ready === 2'b00 && t < 40) begin
      @(negedge clock);
      t++;
    end
    if (req_ready === 2'b00) timeout(tag);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 40) begin
      @(negedge clock);
      t++;
    end
    if (busy !== 1'b0) timeout(tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Memory model: mem_done asserted in the lat-th cycle of a held mem_req.
  initial begin
    model_done = 1'b0;
    mem_cnt    = 0;
    forever begin
      @(negedge clock);
      if (mem_req === 1'b1) begin
        if (mem_cnt + 1 >= lat) begin
          model_done = 1'b1;
          mem_cnt    = 0;
        end else begin
          model_done = 1'b0;
          mem_cnt++;
        end
      end else begin
        model_done = 1'b0;
        mem_cnt    = 0;
      end
    end
  end

  // Response monitor: every resp_valid pulse must match the oldest expected entry.
  initial forever begin
    @(negedge clock);
    if (resp_valid !== 2'b00) begin
      if (sb_q.size() == 0) begin
        chk("resp_unexpected", resp_valid, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_resp_ch", resp_valid, mon_e.ch);
        chk("sb_resp_data", resp_rdata, mon_e.data);
      end
    end
    if (fp_resp_valid !== 3'b000) chk("fp_resp_ch", fp_resp_valid, 3'b001);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    cyc        = 0;
    lat        = 1;
    stray_done = 1'b0;
    rst_n      = 1'b0;
    req_valid  = 2'b01;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    fp_valid   = '0;
    fp_we      = '0;
    fp_addr    = {32'h300, 32'h200, 32'h100};
    fp_wdata   = '0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clock);
    req_valid = 2'b00;
    rst_n     = 1'b1;
    @(negedge clock);

    // Single zero-wait read on ch0.
    req_addr[31:0] = 32'h10;
    req_valid      = 2'b01;
    #1;
    chk("rd_ready", req_ready, 2'b01);
    sb_q.push_back('{ch: 2'b01, data: 32'hDEAD_BEEF});
    @(posedge clock);
    @(negedge clock);
    req_valid = 2'b00;
    chk("rd_mem_req", mem_req, 1);
    chk("rd_mem_addr", mem_addr, 32'h10);
    chk("rd_mem_we", mem_we, 0);
    @(negedge clock);
    chk("rd_resp_valid", resp_valid, 2'b01);
    chk("rd_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
    @(negedge clock);
    chk("rd_busy_low", busy, 0);

    // Write on ch1, 3-cycle latency.
    lat              = 3;
    req_addr[63:32]  = 32'h40;
    req_wdata[63:32] = 32'hCAFE_F00D;
    req_we           = 2'b10;
    req_valid        = 2'b10;
    #1;
    chk("wr_ready", req_ready, 2'b10);
    sb_q.push_back('{ch: 2'b10, data: rd_fn(32'h40)});
    @(posedge clock);
    @(negedge clock);
    req_valid = 2'b00;
    req_we    = 2'b00;
    chk("wr_mem_req", mem_req, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 32'h40);
    chk("wr_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    wait_idle("wr_idle");

    // Round-robin contention, 2-cycle latency: 0,1,0,1 at one grant per 4 cycles.
    lat       = 2;
    req_addr  = {32'h200, 32'h100};
    req_valid = 2'b11;
    #1;
    last_cyc = 0;
    for (int g = 0; g < 4; g++) begin
      wait_ready("rr_ready");
      chk("rr_grant", req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
      if (g > 0) chk("rr_period", cyc - last_cyc, 4);
      last_cyc = cyc;
      sb_q.push_back('{ch: (g % 2 == 0) ? 2'b01 : 2'b10,
                       data: rd_fn((g % 2 == 0) ? 32'h100 : 32'h200)});
      @(posedge clock);
      @(negedge clock);
    end
    req_valid = 2'b00;
    wait_idle("rr_idle");

    // 10-cycle latency: request fields held for the whole ISSUE phase.
    lat            = 10;
    req_addr[31:0] = 32'h80;
    req_valid      = 2'b01;
    #1;
    chk("lat_ready", req_ready, 2'b01);
    sb_q.push_back('{ch: 2'b01, data: rd_fn(32'h80)});
    @(posedge clock);
    @(negedge clock);
    req_valid = 2'b00;
    for (int i = 0; i < 10; i++) begin
      chk("lat_mem_req", mem_req, 1);
      chk("lat_mem_addr", mem_addr, 32'h80);
      chk("lat_mem_we", mem_we, 0);
      @(negedge clock);
    end
    chk("lat_resp_valid", resp_valid, 2'b01);
    @(negedge clock);

    // Stray mem_done while idle.
    stray_done = 1'b1;
    @(negedge clock);
    stray_done = 1'b0;
    chk("stray_busy", busy, 0);
    chk("stray_mem_req", mem_req, 0);
    chk("stray_resp", resp_valid, 0);

    // Reset during ISSUE; ptr is 1 beforehand, so a both-valid probe afterwards exposes it.
    req_valid = 2'b01;
    @(posedge clock);
    @(negedge clock);
    chk("rst_pre_mem_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clock);
    req_valid = 2'b00;
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    req_valid = 2'b11;
    #1;
    chk("rst_ptr_zero", req_ready, 2'b01);
    req_valid = 2'b10;
    #1;
    chk("rst_ch1_ready", req_ready, 2'b10);
    sb_q.push_back('{ch: 2'b10, data: rd_fn(32'h200)});
    @(posedge clock);
    @(negedge clock);
    req_valid = 2'b00;
    chk("rst_ch1_addr", mem_addr, 32'h200);
    wait_idle("rst_idle");

    // Fixed priority: all three channels request continuously; ch0 always wins.
    fp_valid = 3'b111;
    #1;
    for (int g = 0; g < 4; g++) begin
      for (int t = 0; t < 20 && fp_ready === 3'b000; t++) @(negedge clock);
      if (fp_ready === 3'b000) timeout("fp_ready");
      chk("fp_grant", fp_ready, 3'b001);
      @(posedge clock);
      @(negedge clock);
      chk("fp_mem_addr", fp_mem_addr, 32'h100);
    end
    fp_valid = 3'b000;
    repeat (4) @(negedge clock);

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
